vector_ram_arbiter: RTL and testbench
=====================================

Name: vector_ram_arbiter

Overview:
- Shares one vector RAM request/response port between NUM_REQ independent requesters, e.g. SpMV gather engines and a host loader.
- Round-robin arbitration on the request channel, with grant lock until the downstream handshake.
- Read responses return in order through an internal requester-ID FIFO, so each rdata beat reaches the requester that issued it.
- Sits directly in front of vector_ram; the downstream (m_*) side connects 1:1 to the vector_ram request interface.

Parameters:
- NUM_REQ, 4: number of requesters, >=2, power of 2 not required.
- PARALLELISM, 4: lanes per vector access.
- VECTOR_LENGTH, 32: vector depth; sets ADDR_WIDTH.
- DATA_WIDTH, 32: lane data width.
- MAX_OUTSTANDING, 8: read-ID FIFO depth, power of 2.
- ADDR_WIDTH (localparam): $clog2(VECTOR_LENGTH).
- ID_WIDTH (localparam): max(1,$clog2(NUM_REQ)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  NUM_REQ  per-requester request valid
- s_ready  out  NUM_REQ  per-requester request accepted
- s_write  in  NUM_REQ  1=write, 0=read
- s_addr  in  NUM_REQ*PARALLELISM*ADDR_WIDTH  lane addresses, requester r at slice r
- s_wdata  in  NUM_REQ*PARALLELISM*DATA_WIDTH  lane write data
- s_rvalid  out  NUM_REQ  read response valid
- s_rready  in  NUM_REQ  read response ready
- s_rdata  out  PARALLELISM*DATA_WIDTH  shared read data bus, qualified by s_rvalid
- m_valid/m_ready/m_write  out/in/out  1  downstream request handshake
- m_addr  out  PARALLELISM*ADDR_WIDTH
- m_wdata  out  PARALLELISM*DATA_WIDTH
- m_rvalid  in  1;  m_rready  out  1;  m_rdata  in  PARALLELISM*DATA_WIDTH
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
- grant_id  out  ID_WIDTH  currently granted requester; valid when m_valid=1

Behaviour:
- Reset: lock=0, rr_ptr=NUM_REQ-1, FIFO empty, outstanding=0. Outputs s_ready=0, s_rvalid=0, m_valid=0, m_rready=0.
- Reset mid-operation drops all in-flight IDs. Responses arriving later are not routed (m_rready=0 while FIFO empty).
- Eligibility: requester r is eligible when s_valid[r]=1 and (s_write[r]=1 or FIFO not full).
- FSM ARB:
  - Pick the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - m_valid=1 and m_* is muxed from that index, combinationally, same cycle.
  - If m_ready=1: handshake; s_ready[idx]=1; rr_ptr<=idx; stay ARB.
  - Else: go LOCK with lock_idx<=idx.
- FSM LOCK:
  - Grant is held on lock_idx regardless of other requesters; m_* mirrors lock_idx.
  - On m_ready: s_ready[lock_idx]=1; rr_ptr<=lock_idx; go ARB.
  - Requesters must hold valid and payload stable until s_ready. Dropping valid in LOCK is a protocol error; the arbiter returns to ARB without a handshake.
- s_ready[r] is asserted only for the granted index, only in the handshake cycle. Zero-latency pass-through; no request register.
- Read handshake pushes the granted ID into the FIFO; writes push nothing and produce no response.
- Response path:
  - head = FIFO head ID.
  - s_rvalid[head] = m_rvalid & !empty; all other s_rvalid bits = 0.
  - m_rready = s_rready[head] & !empty.
  - s_rdata = m_rdata.
  - Pop on m_rvalid & m_rready.
- Full FIFO blocks reads only; writes continue to be granted. A full FIFO does not break LOCK, because the locked request was eligible when picked. The lock is on the request, and FIFO space is checked at pick.
- Simultaneous read handshake (push) and response pop in one cycle: both happen; outstanding is unchanged; a push is legal when full only if it coincides with a pop.
- outstanding = FIFO occupancy, registered.
- Pointer wrap: FIFO pointers use an extra MSB for the full/empty distinction.

Test Plan:
- Single requester 2 reads addr {0,1,2,3} -> m_valid same cycle; s_ready[2]=1 on m_ready; outstanding goes 1 then 2; both rdata beats delivered on s_rvalid[2] only, in order.
- All 4 requesters valid every cycle, m_ready=1 -> grants 0,1,2,3,0,1 in consecutive cycles, each requester gets 1 in 4.
- m_ready held 0 for 5 cycles with req1 granted and req0 raising valid -> grant_id stays 1 for all 5 cycles; after the req1 handshake the next grant goes to req2 if valid, else req3, req0.
- MAX_OUTSTANDING=8, m_rvalid=0: issue 8 reads -> the 9th read is not granted while a pending write from another requester is granted; one response pop re-enables the read.
- Interleaved reads from req3,req0,req3 with s_rready[0]=0 -> the 2nd response stalls (m_rready=0) until s_rready[0]=1; the 3rd response then goes to req3.
- Assert rst with 3 reads outstanding -> next cycle outstanding=0, all s_ready=0, s_rvalid=0, m_valid=0, m_rready=0, rr_ptr=3 (first grant to req0).

Source files
------------

// File: rtl/vector_ram_arbiter.sv
// vector_ram_arbiter: round-robin sharing of one vector RAM port between
// NUM_REQ requesters, with grant lock until the downstream handshake and an
// in-order requester-ID FIFO that steers read responses back to their issuer.
module vector_ram_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned PARALLELISM     = 4,
    parameter int unsigned VECTOR_LENGTH   = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned ADDR_WIDTH     = $clog2(VECTOR_LENGTH),
    localparam int unsigned ID_WIDTH       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           s_valid,
    output logic [NUM_REQ-1:0]                           s_ready,
    input  logic [NUM_REQ-1:0]                           s_write,
    input  logic [NUM_REQ*PARALLELISM*ADDR_WIDTH-1:0]    s_addr,
    input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0]    s_wdata,
    output logic [NUM_REQ-1:0]                           s_rvalid,
    input  logic [NUM_REQ-1:0]                           s_rready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]            s_rdata,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic                                         m_write,
    output logic [PARALLELISM*ADDR_WIDTH-1:0]            m_addr,
    output logic [PARALLELISM*DATA_WIDTH-1:0]            m_wdata,
    input  logic                                         m_rvalid,
    output logic                                         m_rready,
    input  logic [PARALLELISM*DATA_WIDTH-1:0]            m_rdata,
    output logic [CNT_WIDTH-1:0]                         outstanding,
    output logic [ID_WIDTH-1:0]                          grant_id
);

    localparam int unsigned AVEC_W  = PARALLELISM * ADDR_WIDTH;
    localparam int unsigned DVEC_W  = PARALLELISM * DATA_WIDTH;
    localparam int unsigned FIFO_AW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned PTR_W   = FIFO_AW + 1;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic [ID_WIDTH-1:0]   fifo_mem_q [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0]   fifo_mem_d [MAX_OUTSTANDING];

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [NUM_REQ-1:0]    eligible;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [ID_WIDTH:0]     cand_sum;
    logic [ID_WIDTH-1:0]   cand_id;
    logic                  gnt_valid;
    logic                  gnt_hs;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [ID_WIDTH-1:0]   head_id;
    logic                  push;
    logic                  pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    // Reads need FIFO space to be eligible; writes never produce a response.
    always_comb begin
        eligible = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            eligible[r] = s_valid[r] & (s_write[r] | ~fifo_full);
        end
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_id    = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand_sum = (ID_WIDTH+1)'(rr_ptr_q) + (ID_WIDTH+1)'(k);
            if (cand_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            cand_id = cand_sum[ID_WIDTH-1:0];
            if (!pick_found && eligible[cand_id]) begin
                pick_found = 1'b1;
                pick_idx   = cand_id;
            end
        end
    end

    // Arbitration FSM: grant in ARB, hold the same grant in LOCK until accepted.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        gnt_valid  = 1'b0;
        gnt_hs     = 1'b0;
        gnt_idx    = pick_idx;
        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    gnt_valid = 1'b1;
                    if (m_ready) begin
                        gnt_hs   = 1'b1;
                        rr_ptr_d = pick_idx;
                    end else begin
                        state_d    = ST_LOCK;
                        lock_idx_d = pick_idx;
                    end
                end
            end
            ST_LOCK: begin
                gnt_idx = lock_idx_q;
                if (s_valid[lock_idx_q]) begin
                    gnt_valid = 1'b1;
                    if (m_ready) begin
                        gnt_hs   = 1'b1;
                        rr_ptr_d = lock_idx_q;
                        state_d  = ST_ARB;
                    end
                end else begin
                    // Requester withdrew: release the lock without a transfer.
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
        if (rst) begin
            gnt_valid = 1'b0;
            gnt_hs    = 1'b0;
        end
    end

    // Downstream request mux and per-requester accept strobe.
    always_comb begin
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        s_ready = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (ID_WIDTH'(r) == gnt_idx) begin
                m_write    = s_write[r];
                m_addr     = s_addr[r*AVEC_W +: AVEC_W];
                m_wdata    = s_wdata[r*DVEC_W +: DVEC_W];
                s_ready[r] = gnt_hs;
            end
        end
    end

    assign m_valid  = gnt_valid;
    assign grant_id = gnt_idx;

    // Response steering: the FIFO head owns the shared read-data bus.
    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        head_id  = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
        if (!rst && !fifo_empty) begin
            for (int r = 0; r < int'(NUM_REQ); r++) begin
                if (ID_WIDTH'(r) == head_id) begin
                    s_rvalid[r] = m_rvalid;
                    m_rready    = s_rready[r];
                end
            end
        end
    end

    assign s_rdata = m_rdata;
    assign push    = gnt_hs & ~m_write;
    assign pop     = m_rvalid & m_rready;

    // Read-ID FIFO next state; push and pop in one cycle leave occupancy unchanged.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q[FIFO_AW-1:0]] = gnt_idx;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        outstanding_d = CNT_WIDTH'(wr_ptr_d - rd_ptr_d);
    end

    assign outstanding = outstanding_q;

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ARB;
            rr_ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
            lock_idx_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_idx_q    <= lock_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_vector_ram_arbiter.sv
// Scoreboard bench for vector_ram_arbiter: directed stimulus queues expected
// request handshakes and read responses; a negedge monitor pops and compares.
module tb_vector_ram_arbiter;

    localparam int NR = 4;
    localparam int PAR = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int AV = PAR * AW;
    localparam int DV = PAR * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     s_valid, s_ready, s_write, s_rvalid, s_rready;
    logic [NR*AV-1:0]  s_addr;
    logic [NR*DV-1:0]  s_wdata;
    logic [DV-1:0]     s_rdata, m_wdata, m_rdata;
    logic              m_valid, m_ready, m_write, m_rvalid, m_rready;
    logic [AV-1:0]     m_addr;
    logic [3:0]        outstanding;
    logic [1:0]        grant_id;

    vector_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_write(s_write),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .outstanding(outstanding), .grant_id(grant_id)
    );

    typedef struct packed {
        logic [1:0]    id;
        logic          wr;
        logic [AV-1:0] addr;
        logic [DV-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DV-1:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [AV-1:0] mk_addr(input int base);
        logic [AV-1:0] a;
        for (int l = 0; l < PAR; l++) a[l*AW +: AW] = 5'(base + l);
        return a;
    endfunction

    function automatic logic [DV-1:0] mk_data(input int seed);
        logic [DV-1:0] d;
        for (int l = 0; l < PAR; l++) d[l*DW +: DW] = 32'hD000_0000 + 32'(seed * 16 + l);
        return d;
    endfunction

    task automatic check(input string name, input logic [DV-1:0] act, input logic [DV-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [DV-1:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic wr, input int base);
        s_valid[r]           = v;
        s_write[r]           = wr;
        s_addr[r*AV +: AV]   = mk_addr(base);
        s_wdata[r*DV +: DV]  = mk_data(256 * (r + 1) + base);
    endtask

    task automatic exp_req(input int r, input logic wr, input int base);
        req_t e;
        e.id    = 2'(r);
        e.wr    = wr;
        e.addr  = mk_addr(base);
        e.wdata = mk_data(256 * (r + 1) + base);
        req_q.push_back(e);
    endtask

    task automatic exp_rsp(input int r, input int seed);
        rsp_t e;
        e.id   = 2'(r);
        e.data = mk_data(seed);
        rsp_q.push_back(e);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; s_valid = '0; m_ready = 1'b0; m_rvalid = 1'b0; s_rready = '0;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: compare every request handshake and every delivered response.
    always @(negedge clk) begin
        req_t er;
        rsp_t ep;
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (req_q.size() == 0) begin
                    flag("req_unexpected", DV'(grant_id));
                end else begin
                    er = req_q.pop_front();
                    check("req_id", DV'(grant_id), DV'(er.id));
                    check("req_write", DV'(m_write), DV'(er.wr));
                    check("req_addr", DV'(m_addr), DV'(er.addr));
                    check("req_wdata", m_wdata, er.wdata);
                    check("req_s_ready", DV'(s_ready), DV'(4'(1) << er.id));
                end
            end else if (s_ready != '0) begin
                flag("s_ready_no_handshake", DV'(s_ready));
            end
            if (m_rvalid && m_rready) begin
                if (rsp_q.size() == 0) begin
                    flag("rsp_unexpected", DV'(s_rvalid));
                end else begin
                    ep = rsp_q.pop_front();
                    check("rsp_s_rvalid", DV'(s_rvalid), DV'(4'(1) << ep.id));
                    check("rsp_data", s_rdata, ep.data);
                end
            end else if (s_rvalid != '0 && !m_rvalid) begin
                flag("s_rvalid_no_m_rvalid", DV'(s_rvalid));
            end
        end
    end

    initial begin
        rst = 1'b1; s_valid = '0; s_write = '0; s_addr = '0; s_wdata = '0;
        s_rready = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_outstanding", DV'(outstanding), DV'(0));
        check("rst_m_valid", DV'(m_valid), DV'(0));
        check("rst_m_rready", DV'(m_rready), DV'(0));
        check("rst_s_rvalid", DV'(s_rvalid), DV'(0));

        // Single requester, two reads, in-order delivery to req2
        exp_req(2, 1'b0, 0); exp_req(2, 1'b0, 4);
        tick(); set_req(2, 1'b1, 1'b0, 0); m_ready = 1'b0;
        @(negedge clk);
        check("t1_m_valid_same_cycle", DV'(m_valid), DV'(1));
        check("t1_grant_id", DV'(grant_id), DV'(2));
        check("t1_no_ready_without_m_ready", DV'(s_ready), DV'(0));
        tick(); m_ready = 1'b1;
        tick(); set_req(2, 1'b1, 1'b0, 4);
        @(negedge clk); check("t1_outstanding_1", DV'(outstanding), DV'(1));
        tick(); s_valid = '0; m_ready = 1'b0;
        @(negedge clk); check("t1_outstanding_2", DV'(outstanding), DV'(2));
        exp_rsp(2, 4096); exp_rsp(2, 4097);
        tick(); s_rready = 4'b0100; m_rvalid = 1'b1; m_rdata = mk_data(4096);
        tick(); m_rdata = mk_data(4097);
        tick(); m_rvalid = 1'b0; s_rready = '0;
        @(negedge clk); check("t1_outstanding_0", DV'(outstanding), DV'(0));

        // All requesters valid every cycle: grants 0,1,2,3,0,1
        do_reset();
        exp_req(0, 1'b1, 0); exp_req(1, 1'b1, 4); exp_req(2, 1'b1, 8);
        exp_req(3, 1'b1, 12); exp_req(0, 1'b1, 0); exp_req(1, 1'b1, 4);
        tick();
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b1, r * 4);
        m_ready = 1'b1;
        repeat (5) tick();
        tick(); s_valid = '0; m_ready = 1'b0;
        @(negedge clk); check("t2_writes_no_outstanding", DV'(outstanding), DV'(0));

        // Lock on req1 for 5 stalled cycles, then rotation 2,3,0
        exp_req(1, 1'b1, 12); exp_req(2, 1'b1, 2); exp_req(3, 1'b1, 3); exp_req(0, 1'b1, 1);
        tick(); set_req(1, 1'b1, 1'b1, 12); m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) set_req(0, 1'b1, 1'b1, 1);
            if (c == 2) begin set_req(2, 1'b1, 1'b1, 2); set_req(3, 1'b1, 1'b1, 3); end
            @(negedge clk);
            check("t3_lock_grant_id", DV'(grant_id), DV'(1));
            check("t3_lock_m_valid", DV'(m_valid), DV'(1));
            tick();
        end
        m_ready = 1'b1;
        tick(); s_valid[1] = 1'b0;
        tick();
        tick();
        tick(); s_valid = '0; m_ready = 1'b0;

        // Full read FIFO blocks reads only; one pop re-enables the read
        do_reset();
        for (int k = 0; k < 8; k++) exp_req(0, 1'b0, k);
        exp_req(1, 1'b1, 16); exp_req(0, 1'b0, 8);
        for (int k = 0; k < 8; k++) begin
            tick(); set_req(0, 1'b1, 1'b0, k); m_ready = 1'b1;
        end
        tick(); set_req(0, 1'b1, 1'b0, 8); set_req(1, 1'b1, 1'b1, 16);
        @(negedge clk);
        check("t4_outstanding_full", DV'(outstanding), DV'(8));
        check("t4_read_blocked_write_granted", DV'(grant_id), DV'(1));
        check("t4_no_ready_req0", DV'(s_ready[0]), DV'(0));
        tick(); s_valid[1] = 1'b0;
        @(negedge clk); check("t4_full_no_grant", DV'(m_valid), DV'(0));
        exp_rsp(0, 8192);
        tick(); m_rvalid = 1'b1; s_rready = 4'b0001; m_rdata = mk_data(8192);
        @(negedge clk); check("t4_pop_cycle_no_grant", DV'(m_valid), DV'(0));
        tick(); m_rvalid = 1'b0;
        @(negedge clk);
        check("t4_outstanding_after_pop", DV'(outstanding), DV'(7));
        check("t4_read_reenabled", DV'(m_valid), DV'(1));
        tick(); s_valid = '0; m_ready = 1'b0;
        @(negedge clk); check("t4_outstanding_refull", DV'(outstanding), DV'(8));
        for (int k = 1; k <= 8; k++) exp_rsp(0, 8192 + k);
        for (int k = 1; k <= 8; k++) begin
            tick(); m_rvalid = 1'b1; m_rdata = mk_data(8192 + k);
        end
        tick(); m_rvalid = 1'b0; s_rready = '0;
        @(negedge clk); check("t4_drained", DV'(outstanding), DV'(0));

        // Interleaved reads 3,0,3 with req0 response stalled
        exp_req(3, 1'b0, 20); exp_req(0, 1'b0, 24); exp_req(3, 1'b0, 28);
        tick(); set_req(3, 1'b1, 1'b0, 20); m_ready = 1'b1;
        tick(); s_valid = '0; set_req(0, 1'b1, 1'b0, 24);
        tick(); s_valid = '0; set_req(3, 1'b1, 1'b0, 28);
        tick(); s_valid = '0; m_ready = 1'b0;
        exp_rsp(3, 12288); exp_rsp(0, 12289); exp_rsp(3, 12290);
        s_rready = 4'b1000;
        tick(); m_rvalid = 1'b1; m_rdata = mk_data(12288);
        tick(); m_rdata = mk_data(12289);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t5_stall_m_rready", DV'(m_rready), DV'(0));
            check("t5_stall_s_rvalid", DV'(s_rvalid), DV'(4'b0001));
            tick();
        end
        s_rready = 4'b1001;
        tick(); m_rdata = mk_data(12290);
        @(negedge clk); check("t5_third_to_req3", DV'(s_rvalid), DV'(4'b1000));
        tick(); m_rvalid = 1'b0; s_rready = '0;

        // Reset with three reads in flight
        exp_req(1, 1'b0, 5); exp_req(1, 1'b0, 6); exp_req(1, 1'b0, 7);
        tick(); set_req(1, 1'b1, 1'b0, 5); m_ready = 1'b1;
        tick(); set_req(1, 1'b1, 1'b0, 6);
        tick(); set_req(1, 1'b1, 1'b0, 7);
        tick(); s_valid = '0; m_ready = 1'b0;
        @(negedge clk); check("t6_outstanding_3", DV'(outstanding), DV'(3));
        tick(); rst = 1'b1; m_rvalid = 1'b1; m_rdata = mk_data(99); s_rready = '1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t6_outstanding_cleared", DV'(outstanding), DV'(0));
        check("t6_s_ready", DV'(s_ready), DV'(0));
        check("t6_s_rvalid_dropped", DV'(s_rvalid), DV'(0));
        check("t6_m_valid", DV'(m_valid), DV'(0));
        check("t6_m_rready", DV'(m_rready), DV'(0));
        exp_req(0, 1'b1, 9);
        tick(); m_rvalid = 1'b0; s_rready = '0; m_ready = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b1, 9);
        @(negedge clk); check("t6_first_grant_req0", DV'(grant_id), DV'(0));
        tick(); s_valid = '0; m_ready = 1'b0;

        repeat (3) tick();
        check("end_req_queue_empty", DV'(req_q.size()), DV'(0));
        check("end_rsp_queue_empty", DV'(rsp_q.size()), DV'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
